// File: rtl/game_flow_manager.sv
// Game flow FSM: menu, play and timed died/win/game-over screens with level and lives bookkeeping.
// Optional GFM_AUTO_ADVANCE_EN: a won level continues straight into the next one instead of the menu.
module game_flow_manager #(
  parameter int NUM_LEVELS = 8,
  parameter int LVL_W      = 3,
  parameter int SCREEN_SEC = 3,
  parameter int LIVES_INIT = 3,
  parameter int LIVES_W    = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               one_sec,
  input  logic               bumpy_died,
  input  logic               level_comp,
  input  logic               menu_comp,
  input  logic [LVL_W-1:0]   lvl_selected,
  output logic               menu_screen,
  output logic               died_screen,
  output logic               win_screen,
  output logic               gameover_screen,
  output logic               reset_lvl_N,
  output logic [LVL_W-1:0]   lvl,
  output logic [LIVES_W-1:0] lives
);
  localparam int TMR_W = $clog2(SCREEN_SEC + 1);
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(NUM_LEVELS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCREEN_SEC - 1);

  typedef enum logic [2:0] {MENU, PLAY, DIED, WIN, OVER} state_t;

  state_t             state, state_nx;
  logic [TMR_W-1:0]   timer, timer_nx;
  logic [LVL_W-1:0]   lvl_nx;
  logic [LIVES_W-1:0] lives_nx;
  logic               died_q, comp_q;
  logic               died_edge, comp_edge, timer_done;

  assign died_edge  = bumpy_died & ~died_q;
  assign comp_edge  = level_comp & ~comp_q;
  assign timer_done = one_sec && (timer == TMR_LAST);

  always_comb begin
    state_nx = state;
    lvl_nx   = lvl;
    lives_nx = lives;
    timer_nx = '0;
    case (state)
      MENU: begin
        if (menu_comp) begin
          state_nx = PLAY;
          lvl_nx   = ({1'b0, lvl_selected} >= (LVL_W + 1)'(NUM_LEVELS)) ? LVL_LAST : lvl_selected;
        end
      end
      PLAY: begin
        // Completion wins over a simultaneous death.
        if (comp_edge) begin
          state_nx = WIN;
        end else if (died_edge) begin
          if (lives > LIVES_W'(1)) begin
            state_nx = DIED;
            lives_nx = lives - LIVES_W'(1);
          end else begin
            state_nx = OVER;
            lives_nx = '0;
          end
        end
      end
      DIED: begin
        timer_nx = timer + TMR_W'(one_sec);
        if (timer_done) state_nx = PLAY;
      end
      WIN: begin
        timer_nx = timer + TMR_W'(one_sec);
        if (timer_done) begin
`ifdef GFM_AUTO_ADVANCE_EN
          if (lvl == LVL_LAST) begin
            state_nx = MENU;
            lvl_nx   = '0;
          end else begin
            state_nx = PLAY;
            lvl_nx   = lvl + LVL_W'(1);
          end
`else
          state_nx = MENU;
          lvl_nx   = (lvl == LVL_LAST) ? '0 : lvl + LVL_W'(1);
`endif
        end
      end
      OVER: begin
        timer_nx = timer + TMR_W'(one_sec);
        if (timer_done) begin
          state_nx = MENU;
          lvl_nx   = '0;
          lives_nx = LIVES_W'(LIVES_INIT);
        end
      end
      default: state_nx = MENU;
    endcase
    // Leaving a timed screen (or never having been in one) leaves the timer cleared for the next entry.
    if (state_nx != state) timer_nx = '0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= MENU;
      timer           <= '0;
      lvl             <= '0;
      lives           <= LIVES_W'(LIVES_INIT);
      died_q          <= 1'b0;
      comp_q          <= 1'b0;
      menu_screen     <= 1'b1;
      died_screen     <= 1'b0;
      win_screen      <= 1'b0;
      gameover_screen <= 1'b0;
      reset_lvl_N     <= 1'b0;
    end else begin
      state           <= state_nx;
      timer           <= timer_nx;
      lvl             <= lvl_nx;
      lives           <= lives_nx;
      died_q          <= bumpy_died;
      comp_q          <= level_comp;
      menu_screen     <= (state_nx == MENU);
      died_screen     <= (state_nx == DIED);
      win_screen      <= (state_nx == WIN);
      gameover_screen <= (state_nx == OVER);
      reset_lvl_N     <= (state_nx == PLAY);
    end
  end
endmodule
